// File: rtl/hash_tx_serializer_if.sv
// hash_tx_serializer_if: parallel hash capture plus byte-wide valid/ready transmit bundle.
interface hash_tx_if #(
    parameter int HASH_W = 326
);
    logic [HASH_W-1:0] hash;
    logic              hash_valid;
    logic              busy;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;
    logic              done;
    logic              overrun;

    modport master (
        output hash, hash_valid, tx_ready,
        input  busy, tx_data, tx_valid, tx_last, done, overrun
    );

    modport slave (
        input  hash, hash_valid, tx_ready,
        output busy, tx_data, tx_valid, tx_last, done, overrun
    );
endinterface

// File: rtl/hash_tx_serializer.sv
// hash_tx_serializer: captures the bcrypt result and streams it MSB byte first over valid/ready.
// Define HASH_TX_CKSUM_EN to append an XOR checksum byte to each frame.
module hash_tx_serializer #(
    parameter int HASH_W = 326,
    parameter int NBYTES = 41
) (
    input  logic     clk,
    input  logic     rst,
    hash_tx_if.slave bus_io
);
    localparam int CW = $clog2(NBYTES + 1);
    localparam int FW = 8 * NBYTES;

    typedef enum logic [1:0] {
        IDLE,
        SEND
`ifdef HASH_TX_CKSUM_EN
        , CKSUM
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [FW-1:0]  sr_q, sr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
    logic           ovr_q, ovr_d;
    logic           busy_w, xfer_w, last_data_w;
    logic [7:0]     cur_w;
`ifdef HASH_TX_CKSUM_EN
    logic [7:0]     acc_q, acc_d;
`endif

    assign busy_w      = state_q != IDLE;
    assign xfer_w      = busy_w && bus_io.tx_ready;
    assign cur_w       = sr_q[FW-1 -: 8];
    assign last_data_w = cnt_q == CW'(NBYTES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef HASH_TX_CKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
`ifdef HASH_TX_CKSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    // The final data transfer still counts as busy, so a coincident capture is an overrun.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q | (bus_io.hash_valid & busy_w);
`ifdef HASH_TX_CKSUM_EN
        acc_d   = acc_q;
`endif
        if (state_q == IDLE && bus_io.hash_valid) begin
            sr_d    = FW'(bus_io.hash);
            cnt_d   = '0;
            state_d = SEND;
`ifdef HASH_TX_CKSUM_EN
            acc_d   = '0;
`endif
        end else if (state_q == SEND && xfer_w) begin
            sr_d  = sr_q << 8;
            cnt_d = cnt_q + CW'(1);
`ifdef HASH_TX_CKSUM_EN
            acc_d = acc_q ^ cur_w;
            if (last_data_w) state_d = CKSUM;
`else
            if (last_data_w) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
`endif
        end
`ifdef HASH_TX_CKSUM_EN
        else if (state_q == CKSUM && xfer_w) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
`endif
    end

    assign bus_io.busy     = busy_w;
    assign bus_io.tx_valid = busy_w;
    assign bus_io.done     = done_q;
    assign bus_io.overrun  = ovr_q;
`ifdef HASH_TX_CKSUM_EN
    assign bus_io.tx_data  = (state_q == CKSUM) ? acc_q : cur_w;
    assign bus_io.tx_last  = state_q == CKSUM;
`else
    assign bus_io.tx_data  = cur_w;
    assign bus_io.tx_last  = state_q == SEND && last_data_w;
`endif
endmodule
